// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures the period and high time of a divided clock that
// is sampled as data in the source clock domain. It declares lock after a run
// of good periods and reports period, duty and stuck-clock faults.
module div_clk_monitor #(
    parameter int DIV_N    = 9,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_clk_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             fault,
    output logic             stuck,
    output logic             meas_vld,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED, S_FAULT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PER_EXP   = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0] PER_LIMIT = CNT_W'(2 * DIV_N);
    localparam logic [CNT_W-1:0] HIGH_LO   = CNT_W'(DIV_N / 2);
    localparam logic [CNT_W-1:0] HIGH_HI   = CNT_W'((DIV_N + 1) / 2);
    localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    logic             sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0] perCnt_q, perCnt_d;
    logic [CNT_W-1:0] hiCnt_q, hiCnt_d;
    logic [CNT_W-1:0] period_q, high_q;
    logic             measVld_q;
    logic [3:0]       goodCnt_q, goodCnt_d;
    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic             stuck_q, stuck_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    state_t           state_q, state_d;

    logic rise;
    logic timeout;
    logic capture;
    logic measOk;
    logic badMeas;
    logic errEvent;

    // Event decode: a rising edge of the resynchronised clock, a period counter
    // that hit the stuck limit without a new edge, and measurement validity.
    assign rise     = sync2_q & ~sync3_q;
    assign timeout  = ~rise & (perCnt_q == PER_LIMIT);
    assign capture  = rise & (state_q != S_IDLE);
    assign measOk   = (perCnt_q == PER_EXP) && ((hiCnt_q == HIGH_LO) || (hiCnt_q == HIGH_HI));
    assign badMeas  = capture & ~measOk;
    assign errEvent = timeout | badMeas;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= div_clk_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Period counter restarts on each edge and after a timeout; high counter
    // restarts on each edge and counts cycles where the sampled clock is high.
    always_comb begin
        perCnt_d = perCnt_q;
        hiCnt_d  = hiCnt_q;
        if (rise) begin
            perCnt_d = CNT_ONE;
        end else if (timeout) begin
            perCnt_d = '0;
        end else if (perCnt_q != '1) begin
            perCnt_d = perCnt_q + CNT_ONE;
        end
        if (rise) begin
            hiCnt_d = CNT_ONE;
        end else if (sync2_q) begin
            hiCnt_d = hiCnt_q + CNT_ONE;
        end
    end

    // Error counter saturates; stuck is sticky; a clear always wins.
    always_comb begin
        errCnt_d = errCnt_q;
        stuck_d  = stuck_q;
        if (clr_err) begin
            errCnt_d = '0;
            stuck_d  = 1'b0;
        end else begin
            if (errEvent && (errCnt_q != '1)) begin
                errCnt_d = errCnt_q + ERR_ONE;
            end
            if (timeout) begin
                stuck_d = 1'b1;
            end
        end
    end

    // Counter, measurement and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perCnt_q  <= '0;
            hiCnt_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            measVld_q <= 1'b0;
            errCnt_q  <= '0;
            stuck_q   <= 1'b0;
        end else begin
            perCnt_q  <= perCnt_d;
            hiCnt_q   <= hiCnt_d;
            measVld_q <= capture;
            errCnt_q  <= errCnt_d;
            stuck_q   <= stuck_d;
            if (capture) begin
                period_q <= perCnt_q;
                high_q   <= hiCnt_q;
            end
        end
    end

    // FSM state register together with the good-period run counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            goodCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            goodCnt_q <= goodCnt_d;
        end
    end

    // FSM next-state: acquire a run of good periods, lock, and drop to FAULT
    // on any bad measurement or stall once locked.
    always_comb begin
        state_d   = state_q;
        goodCnt_d = goodCnt_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d   = S_ACQ;
                    goodCnt_d = '0;
                end
            end
            S_ACQ: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (capture) begin
                    if (measOk) begin
                        goodCnt_d = goodCnt_q + 4'd1;
                        if ((goodCnt_q + 4'd1) == LOCK_TGT) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        goodCnt_d = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (timeout || badMeas) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clr_err) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output decode, registered so locked/fault follow the state by a cycle.
    always_comb begin
        locked_d = (state_q == S_LOCKED);
        fault_d  = (state_q == S_FAULT);
    end

    // Registered status decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign locked   = locked_q;
    assign fault    = fault_q;
    assign stuck    = stuck_q;
    assign meas_vld = measVld_q;
    assign period_o = period_q;
    assign high_o   = high_q;
    assign err_cnt  = errCnt_q;

endmodule
